// File: rtl/dma_sched_pkg.sv
// Shared types and widths for the DMA scheduler: FSM states and the latched
// transfer descriptor handed to the block-copy engine.
package dma_sched_pkg;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;
    localparam int ID_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        RETIRE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
    } desc_t;

endpackage

// File: rtl/dma_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr_i,
// wrapping. The pointer itself is owned by the scheduler.
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] id_o,
    output logic            any_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        id_o    = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_scheduler.sv
// Shares one block-copy DMA engine between NREQ requesters: round-robin grant,
// descriptor latch, clean ctrl rising edge per transfer, and done/err pulses.
module dma_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rdy,
    input  logic [NREQ-1:0]        req,
    input  logic [ADDR_W*NREQ-1:0] req_src,
    input  logic [ADDR_W*NREQ-1:0] req_dst,
    input  logic [LEN_W*NREQ-1:0]  req_len,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic                   dma_ctrl,
    output logic [ADDR_W-1:0]      dma_src_addr,
    output logic [ADDR_W-1:0]      dma_dst_addr,
    output logic [LEN_W-1:0]       dma_length,
    input  logic                   dma_busy,
    output logic                   active,
    output logic [ID_W-1:0]        cur_id
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e           state_q;
    desc_t            desc_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  cur_id_q;
    logic [WD_W-1:0]  wd_q;
    logic             ctrl_q;
    logic [NREQ-1:0]  done_q;
    logic [NREQ-1:0]  err_q;

    logic [NREQ-1:0]  arb_grant;
    logic [ID_W-1:0]  arb_id;
    logic             arb_any;
    desc_t            win_desc;
    logic [NREQ-1:0]  cur_onehot;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (int'(id) >= NREQ - 1) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .id_o    (arb_id),
        .any_o   (arb_any)
    );

    always_comb begin
        win_desc   = '0;
        cur_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                win_desc.src = req_src[i*ADDR_W +: ADDR_W];
                win_desc.dst = req_dst[i*ADDR_W +: ADDR_W];
                win_desc.len = req_len[i*LEN_W +: LEN_W];
            end
            cur_onehot[i] = (int'(cur_id_q) == i);
        end
    end

    // Every register holds when rdy=0; the pulse registers are cleared on the
    // next rdy cycle so each pulse is seen for exactly one enabled clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            desc_q   <= '0;
            ptr_q    <= '0;
            cur_id_q <= '0;
            wd_q     <= '0;
            ctrl_q   <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
        end else if (rdy) begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    // A pending pulse blocks one cycle so its requester can drop req.
                    if (!dma_busy && arb_any && (done_q == '0)) begin
                        desc_q   <= win_desc;
                        cur_id_q <= arb_id;
                        wd_q     <= '0;
                        if (win_desc.len == '0) begin
                            done_q <= arb_grant;
                            ptr_q  <= wrap_inc(arb_id);
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (dma_busy) begin
                        ctrl_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (wd_q == WD_LAST) begin
                        ctrl_q  <= 1'b0;
                        err_q   <= cur_onehot;
                        state_q <= RETIRE;
                    end else begin
                        ctrl_q <= 1'b1;
                        wd_q   <= wd_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!dma_busy) begin
                        ctrl_q  <= 1'b0;
                        done_q  <= cur_onehot;
                        state_q <= RETIRE;
                    end
                end
                RETIRE: begin
                    ctrl_q  <= 1'b0;
                    ptr_q   <= wrap_inc(cur_id_q);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done         = done_q & {NREQ{rdy}};
    assign err          = err_q & {NREQ{rdy}};
    assign dma_ctrl     = ctrl_q;
    assign dma_src_addr = desc_q.src;
    assign dma_dst_addr = desc_q.dst;
    assign dma_length   = desc_q.len;
    assign active       = (state_q != IDLE);
    assign cur_id       = cur_id_q;

endmodule
